// File: rtl/operand_fetch.sv
// Operand-fetch stage: sequences up to two reads through a single synchronous
// register-file read port and bypasses write-back data into the operand pair.
module operand_fetch #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_rs_a,
  input  logic [AW-1:0] req_rs_b,
  input  logic          req_need_b,
  output logic [AW-1:0] rf_read_addr,
  input  logic [DW-1:0] rf_q,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b
);

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] rs_a_reg, rs_a_next;
  logic [AW-1:0] rs_b_reg, rs_b_next;
  logic          need_b_reg, need_b_next;
  logic          byp_a_reg, byp_a_next;
  logic          byp_b_reg, byp_b_next;
  logic [DW-1:0] byp_data_a_reg, byp_data_a_next;
  logic [DW-1:0] byp_data_b_reg, byp_data_b_next;
  logic [DW-1:0] op_a_reg, op_a_next;
  logic [DW-1:0] op_b_reg, op_b_next;
  logic          op_valid_reg, op_valid_next;

  logic          hit_a, hit_b;
  logic [DW-1:0] cap_a, cap_b;

  // A write landing on the capture edge is the newest value; otherwise a write
  // that collided with the read-sampling edge overrides the stale file output.
  assign hit_a = wb_we && (wb_addr == rs_a_reg);
  assign hit_b = wb_we && (wb_addr == rs_b_reg);
  assign cap_a = hit_a ? wb_data : (byp_a_reg ? byp_data_a_reg : rf_q);
  assign cap_b = hit_b ? wb_data : (byp_b_reg ? byp_data_b_reg : rf_q);

  assign req_ready = (state_reg == IDLE);
  assign op_valid  = op_valid_reg;
  assign op_a      = op_a_reg;
  assign op_b      = op_b_reg;

  always_comb begin
    rf_read_addr = rs_a_reg;
    case (state_reg)
      IDLE:    rf_read_addr = req_rs_a;
      RD_A:    rf_read_addr = rs_b_reg;
      default: rf_read_addr = rs_a_reg;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    rs_a_next       = rs_a_reg;
    rs_b_next       = rs_b_reg;
    need_b_next     = need_b_reg;
    byp_a_next      = byp_a_reg;
    byp_b_next      = byp_b_reg;
    byp_data_a_next = byp_data_a_reg;
    byp_data_b_next = byp_data_b_reg;
    op_a_next       = op_a_reg;
    op_b_next       = op_b_reg;
    op_valid_next   = op_valid_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          rs_a_next       = req_rs_a;
          rs_b_next       = req_rs_b;
          need_b_next     = req_need_b;
          byp_a_next      = wb_we && (wb_addr == req_rs_a);
          byp_data_a_next = wb_data;
          state_next      = RD_A;
        end
      end
      RD_A: begin
        op_a_next = cap_a;
        if (need_b_reg) begin
          byp_b_next      = hit_b;
          byp_data_b_next = wb_data;
          state_next      = RD_B;
        end else begin
          op_b_next     = '0;
          op_valid_next = 1'b1;
          state_next    = HOLD;
        end
      end
      RD_B: begin
        op_b_next     = cap_b;
        op_valid_next = 1'b1;
        state_next    = HOLD;
        if (hit_a) begin
          op_a_next = wb_data;
        end
      end
      HOLD: begin
        // The pair handed over on the handshake edge is the pre-edge value.
        if (op_ready) begin
          op_valid_next = 1'b0;
          state_next    = IDLE;
        end else begin
          if (hit_a) begin
            op_a_next = wb_data;
          end
          if (need_b_reg && hit_b) begin
            op_b_next = wb_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rs_a_reg       <= '0;
      rs_b_reg       <= '0;
      need_b_reg     <= 1'b0;
      byp_a_reg      <= 1'b0;
      byp_b_reg      <= 1'b0;
      byp_data_a_reg <= '0;
      byp_data_b_reg <= '0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rs_a_reg       <= rs_a_next;
      rs_b_reg       <= rs_b_next;
      need_b_reg     <= need_b_next;
      byp_a_reg      <= byp_a_next;
      byp_b_reg      <= byp_b_next;
      byp_data_a_reg <= byp_data_a_next;
      byp_data_b_reg <= byp_data_b_next;
      op_a_reg       <= op_a_next;
      op_b_reg       <= op_b_next;
      op_valid_reg   <= op_valid_next;
    end
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage that sits directly downstream of the 8x8 dual-port register file.
- Accepts a decoded register-read request, sequences up to two reads through the file's single synchronous read port (1-cycle read latency), and bypasses same-cycle and in-flight write-back data.
- Presents a coherent operand pair to the ALU stage over a valid/ready handshake.

Parameters:
- DW, 8, operand/register data width
- AW, 3, register address width (2**AW registers)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  decode presents a request
- req_ready  out  1  stage can accept a request
- req_rs_a  in  AW  source register A
- req_rs_b  in  AW  source register B
- req_need_b  in  1  1 = fetch B; 0 = single-operand instruction
- rf_read_addr  out  AW  to register-file read_addr
- rf_q  in  DW  from register-file q
- wb_we  in  1  write-back enable (same signal as register-file we)
- wb_addr  in  AW  write-back address (same as register-file write_addr)
- wb_data  in  DW  write-back data (same as register-file data)
- op_valid  out  1  operand pair valid
- op_ready  in  1  ALU stage accepts
- op_a  out  DW  operand A
- op_b  out  DW  operand B (0 when need_b=0)

Behaviour:
- Reset (async assert, sync release): state=IDLE; op_valid=0; op_a=0; op_b=0; internal address/bypass registers=0. req_ready=1 after reset.
- Assertion mid-operation aborts the fetch. No output is produced for the aborted request.
- FSM states are IDLE, RD_A, RD_B, HOLD.
- req_ready = (state==IDLE). Combinational; does not depend on req_valid.
- rf_read_addr is combinational:
  - IDLE: req_rs_a
  - RD_A: rs_b_r
  - RD_B, HOLD: rs_a_r
- IDLE: on req_valid, latch rs_a_r, rs_b_r and need_b_r, then go to RD_A. The register file samples A on this edge.
- RD_A: capture op_a.
  - need_b_r=1: go to RD_B. The register file samples B on this edge.
  - need_b_r=0: set op_b=0, set op_valid=1, go to HOLD.
- RD_B: capture op_b, set op_valid=1, go to HOLD.
- HOLD: on op_ready, clear op_valid and go to IDLE. op_a/op_b stay stable except for write tracking (below).
- Latency: request accepted on edge 0; op_valid high after edge 2 (need_b=1) or after edge 1 (need_b=0).
- Minimum request spacing is 3 cycles (need_b=0) or 4 cycles (need_b=1) with op_ready held high.
- Coherency rule: delivered operands equal the register contents after every write whose wb_we edge precedes the op handshake edge.
- Sample-edge bypass:
  - The register file returns old data when a read and a write to the same address hit the same edge.
  - On each read-sampling edge, record byp_x = wb_we && wb_addr==addr_x, and byp_data_x = wb_data.
- Capture-edge value for operand x:
  - if wb_we && wb_addr==addr_x: wb_data (newest)
  - else if byp_x: byp_data_x
  - else: rf_q
- Write tracking: in RD_B and HOLD, any wb_we with wb_addr==rs_a_r updates op_a. In HOLD with need_b_r=1, a match on rs_b_r updates op_b. If rs_a_r==rs_b_r, both update.
- Handshake edge: a write on the same edge as the op_valid&&op_ready handshake is not reflected in the delivered pair.
- rs_a==rs_b still performs two reads. No special casing.
- op_valid never drops without op_ready. op_a/op_b change in HOLD only through write tracking.

Test Plan:
- Reset, preload R2=0x11 and R5=0x22; request a=2, b=5, need_b=1, op_ready=1 -> op_valid high 2 cycles after accept, op_a=0x11, op_b=0x22, rf_read_addr sequence 2,5.
- Request a=3, need_b=0 with R3=0x7F -> op_valid 1 cycle after accept, op_a=0x7F, op_b=0x00.
- Same-edge hazard: write R4=0xA5 on the accept edge of request a=4 (old R4=0x00) -> op_a=0xA5.
- In-flight hazard: write R6=0x3C on the edge after B is sampled for request b=6 (old 0x01) -> op_b=0x3C.
- Hold tracking: op_ready=0 for 5 cycles after op_valid; write R1=0x99 while holding a=b=1 -> op_a=op_b=0x99 before the handshake. No change after op_ready.
- Back-pressure and reset: assert rst_n=0 in RD_A -> op_valid=0 and req_ready=1 after release; the next request completes normally with correct data.
